// File: rtl/mte_frame_decrypt_checker_pkg.sv
// Shared types and helpers for the MTE encrypt/decrypt paths (package mte_pkg).
package mte_pkg;

  localparam int N_DEF = 8;
  localparam int ROTW  = $clog2(N_DEF);

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } mte_state_e;

  // Upper half of the doubled word is the key rotated left by amt.
  function automatic logic [N_DEF-1:0] rotl_key(input logic [N_DEF-1:0] key,
                                                input logic [ROTW-1:0]  amt);
    logic [2*N_DEF-1:0] dbl;
    dbl = {key, key} << amt;
    return dbl[2*N_DEF-1:N_DEF];
  endfunction

  function automatic logic [N_DEF-1:0] exp_tag(input logic [N_DEF-1:0] mac_acc,
                                               input logic [N_DEF-1:0] key);
    return mac_acc ^ key;
  endfunction

endpackage

// File: rtl/mte_frame_decrypt_checker_if.sv
// Stream and verdict bundle between link receiver, checker and plaintext consumer.
interface mte_frame_decrypt_checker_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         frame_done;
  logic         frame_ok;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, frame_done, frame_ok
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, frame_done, frame_ok
  );
endinterface

// File: rtl/mte_frame_decrypt_checker_out_slice.sv
// Single valid/ready register slice for the plaintext stream.
module mte_out_slice #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [N-1:0] data_o,
  output logic         can_accept_o
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;

  // Load has priority; otherwise a handoff empties the slice.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= {N{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign can_accept_o = !valid_q || ready_i;

endmodule

// File: rtl/mte_frame_decrypt_checker.sv
// MTE receive side: decrypts data beats, checks the trailing MAC tag, reports a verdict.
// Optional MTE_FAIL_COUNT_EN adds a saturating failed-frame counter output.
module mte_frame_decrypt_checker
  import mte_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int MAX_LEN = 16,
  parameter int IDXW    = $clog2(MAX_LEN + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          key_load,
  input  logic [N-1:0]                  key_in,
  output logic                          key_valid,
  mte_frame_decrypt_checker_if.slave    bus
`ifdef MTE_FAIL_COUNT_EN
  ,
  output logic [15:0]                   fail_count
`endif
);

  localparam logic [1:0]      S_NOKEY = NOKEY;
  localparam logic [1:0]      S_IDLE  = IDLE;
  localparam logic [1:0]      S_RUN   = RUN;
  localparam logic [1:0]      S_DONE  = DONE;
  localparam logic [IDXW-1:0] MAX_IDX = IDXW'(MAX_LEN);
  localparam logic [IDXW-1:0] IDX_ONE = {{(IDXW-1){1'b0}}, 1'b1};
  localparam int              RW      = $clog2(N);

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    key_q, key_d;
  logic [N-1:0]    act_q, act_d;
  logic            kv_q, kv_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    mac_q, mac_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            ok_q, ok_d;

  logic            can_accept_s, in_ready_s, beat_s, data_beat_s, tag_beat_s;
  logic            room_s, fwd_s, key_nz_s, verdict_s;
  logic [N-1:0]    cur_key_s, plain_s;

  assign in_ready_s  = ((state_q == S_IDLE) || (state_q == S_RUN)) && can_accept_s;
  assign beat_s      = bus.in_valid && in_ready_s;
  assign data_beat_s = beat_s && !bus.in_last;
  assign tag_beat_s  = beat_s && bus.in_last;
  assign room_s      = (idx_q != MAX_IDX);
  assign fwd_s       = data_beat_s && room_s;
  assign key_nz_s    = (key_in != {N{1'b0}});
  // The frame's key is latched on its first beat so a concurrent reload only hits the next frame.
  assign cur_key_s   = (state_q == S_RUN) ? act_q : key_q;
  assign plain_s     = bus.in_data ^ rotl_key(cur_key_s, idx_q[RW-1:0]);
  assign verdict_s   = (bus.in_data == exp_tag(mac_q, cur_key_s)) && !ovf_q;

  // Frame FSM, key handling and MAC accumulation.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    act_d   = act_q;
    kv_d    = kv_q;
    idx_d   = idx_q;
    mac_d   = mac_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    case (state_q)
      S_NOKEY: begin
        if (key_load) begin
          key_d   = key_in;
          kv_d    = key_nz_s;
          state_d = key_nz_s ? S_IDLE : S_NOKEY;
        end else begin
          state_d = S_NOKEY;
        end
      end
      S_IDLE: begin
        if (key_load) begin
          key_d   = key_in;
          kv_d    = key_nz_s;
          state_d = key_nz_s ? S_IDLE : S_NOKEY;
        end else begin
          state_d = S_IDLE;
        end
        if (data_beat_s) begin
          state_d = S_RUN;
          act_d   = key_q;
          idx_d   = idx_q + IDX_ONE;
          mac_d   = mac_q ^ plain_s;
        end else if (tag_beat_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ok_d    = verdict_s;
        end else begin
          act_d = act_q;
        end
      end
      S_RUN: begin
        if (data_beat_s) begin
          if (room_s) begin
            idx_d = idx_q + IDX_ONE;
            mac_d = mac_q ^ plain_s;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (tag_beat_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ok_d    = verdict_s;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        idx_d   = {IDXW{1'b0}};
        mac_d   = {N{1'b0}};
        ovf_d   = 1'b0;
        state_d = kv_q ? S_IDLE : S_NOKEY;
      end
      default: begin
        state_d = S_NOKEY;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_NOKEY;
      key_q   <= {N{1'b0}};
      act_q   <= {N{1'b0}};
      kv_q    <= 1'b0;
      idx_q   <= {IDXW{1'b0}};
      mac_q   <= {N{1'b0}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      act_q   <= act_d;
      kv_q    <= kv_d;
      idx_q   <= idx_d;
      mac_q   <= mac_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  mte_out_slice #(.N(N)) u_out_slice (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_i       (fwd_s),
    .data_i       (plain_s),
    .ready_i      (bus.out_ready),
    .valid_o      (bus.out_valid),
    .data_o       (bus.out_data),
    .can_accept_o (can_accept_s)
  );

  assign bus.in_ready   = in_ready_s;
  assign bus.frame_done = done_q;
  assign bus.frame_ok   = ok_q;
  assign key_valid      = kv_q;

`ifdef MTE_FAIL_COUNT_EN
  logic [15:0] fail_q, fail_d;

  // Saturating count of frames that ended with a failing verdict.
  always_comb begin
    if (done_q && !ok_q && (fail_q != 16'hFFFF)) begin
      fail_d = fail_q + 16'd1;
    end else begin
      fail_d = fail_q;
    end
  end

  // Fail counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fail_q <= 16'd0;
    end else begin
      fail_q <= fail_d;
    end
  end

  assign fail_count = fail_q;
`endif

endmodule

// File: tb/tb_mte_frame_decrypt_checker.sv
// Directed bench: frame-level model with expected-output/verdict queues and a per-cycle compare process.
module tb_mte_frame_decrypt_checker;

  localparam int MAXL = 16;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_load = 1'b0;
  logic [7:0] key_in   = 8'h00;
  logic       key_valid;
`ifdef MTE_FAIL_COUNT_EN
  logic [15:0] fail_count;
`endif

  mte_frame_decrypt_checker_if #(.N(8)) bus();

  mte_frame_decrypt_checker dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_valid (key_valid),
    .bus       (bus)
`ifdef MTE_FAIL_COUNT_EN
    ,
    .fail_count(fail_count)
`endif
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  int         stall_cycles = 0;
  int         exp_fails = 0;
  logic [7:0] exp_out_q[$];
  logic       exp_ok_q[$];
  logic [7:0] pt_buf[0:19];
  logic [7:0] sent_log[0:19];
  logic [7:0] sent_tag;
  logic       ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Plain bit-by-bit rotate, independent of how the design rotates.
  function automatic logic [7:0] m_rot(input logic [7:0] k, input int s);
    logic [7:0] r;
    r = k;
    for (int j = 0; j < (s % 8); j++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic do_load(input logic [7:0] k);
    @(negedge clock);
    key_load = 1'b1;
    key_in   = k;
    @(posedge clock);
    #1;
    key_load = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) fail_now("in_ready timeout");
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_ok_q.size() != 0 || exp_out_q.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) fail_now("frame completion timeout");
    repeat (2) @(negedge clock);
`ifdef MTE_FAIL_COUNT_EN
    chk("fail_count", fail_count, exp_fails);
`endif
  endtask

  // Model a frame from plaintext: derive ciphertext, expected outputs, tag and verdict.
  task automatic run_frame(input logic [7:0] k, input int len, input logic [7:0] tag_xor,
                           output logic f_ok);
    logic [7:0] mac;
    mac = 8'h00;
    for (int i = 0; i < len; i++) begin
      sent_log[i] = pt_buf[i] ^ m_rot(k, i);
      if (i < MAXL) begin
        exp_out_q.push_back(pt_buf[i]);
        mac = mac ^ pt_buf[i];
      end
    end
    sent_tag = mac ^ k ^ tag_xor;
    f_ok = (tag_xor == 8'h00) && (len <= MAXL);
    exp_ok_q.push_back(f_ok);
    if (!f_ok) exp_fails++;
    for (int i = 0; i < len; i++) send(sent_log[i], 1'b0);
    send(sent_tag, 1'b1);
    wait_done();
  endtask

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  // Compare process: every output handoff, verdict and stall cycle is checked.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_out_q.size() == 0) fail_now("unexpected output beat");
          else chk("out_data", bus.out_data, exp_out_q.pop_front());
        end
        if (bus.frame_done) begin
          if (exp_ok_q.size() == 0) fail_now("unexpected frame_done");
          else chk("frame_ok", bus.frame_ok, exp_ok_q.pop_front());
        end
        if (prev_stall) begin
          chk("held out_valid", bus.out_valid, 1'b1);
          chk("held out_data", bus.out_data, prev_data);
        end
        if (bus.out_valid && !bus.out_ready) begin
          chk("stall in_ready", bus.in_ready, 1'b0);
          stall_cycles++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst key_valid", key_valid, 1'b0);
    chk("rst in_ready", bus.in_ready, 1'b0);
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst out_data", bus.out_data, 8'h00);
    chk("rst frame_done", bus.frame_done, 1'b0);
    chk("rst frame_ok", bus.frame_ok, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    chk("model rot1", m_rot(8'h0F, 1), 8'h1E);
    chk("model rot9", m_rot(8'h81, 9), 8'h03);

    // No key: offered beats are refused.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (4) begin
      @(negedge clock);
      chk("nokey in_ready", bus.in_ready, 1'b0);
      chk("nokey out_valid", bus.out_valid, 1'b0);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    do_load(8'h00);
    @(negedge clock);
    chk("zero key key_valid", key_valid, 1'b0);
    chk("zero key in_ready", bus.in_ready, 1'b0);
    do_load(8'h0F);
    @(negedge clock);
    chk("key_valid", key_valid, 1'b1);
    chk("idle in_ready", bus.in_ready, 1'b1);

    // Good frame.
    pt_buf[0] = 8'h01;
    pt_buf[1] = 8'h02;
    run_frame(8'h0F, 2, 8'h00, ok);
    chk("good cipher0", sent_log[0], 8'h0E);
    chk("good cipher1", sent_log[1], 8'h1C);
    chk("good tag", sent_tag, 8'h0C);
    chk("good model ok", ok, 1'b1);

    // Bad tag.
    run_frame(8'h0F, 2, 8'h01, ok);
    chk("bad tag", sent_tag, 8'h0D);
    chk("bad model ok", ok, 1'b0);

    // Zero-length frame.
    do_load(8'h0A);
    run_frame(8'h0A, 0, 8'h00, ok);
    chk("zero-len tag", sent_tag, 8'h0A);
    chk("zero-len model ok", ok, 1'b1);

    // Backpressure mid-frame.
    do_load(8'h3C);
    for (int i = 0; i < 8; i++) pt_buf[i] = 8'((i + 1) * 16 + i);
    stall_cycles = 0;
    fork
      run_frame(8'h3C, 8, 8'h00, ok);
      begin
        repeat (2) @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    chk("stall cycles seen", (stall_cycles >= 3), 1'b1);

    // Overflow: MAX_LEN+1 data beats.
    do_load(8'hA5);
    for (int i = 0; i < 17; i++) pt_buf[i] = 8'(i * 7 + 3);
    run_frame(8'hA5, 17, 8'h00, ok);
    chk("ovf model ok", ok, 1'b0);

    // Reset mid-frame.
    do_load(8'h5A);
    for (int i = 0; i < 3; i++) begin
      pt_buf[i] = 8'(8'hC0 + i);
      exp_out_q.push_back(pt_buf[i]);
      send(pt_buf[i] ^ m_rot(8'h5A, i), 1'b0);
    end
    repeat (3) @(negedge clock);
    chk("pre-reset outputs drained", exp_out_q.size(), 0);
    #2;
    reset_n = 1'b0;
    exp_fails = 0;
    #1;
    chk("midrst key_valid", key_valid, 1'b0);
    chk("midrst in_ready", bus.in_ready, 1'b0);
    chk("midrst out_valid", bus.out_valid, 1'b0);
    chk("midrst frame_done", bus.frame_done, 1'b0);
`ifdef MTE_FAIL_COUNT_EN
    chk("midrst fail_count", fail_count, 16'd0);
`endif
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("post-reset key_valid", key_valid, 1'b0);
      chk("post-reset frame_done", bus.frame_done, 1'b0);
    end

    // Recovery after reload.
    do_load(8'h33);
    for (int i = 0; i < 4; i++) pt_buf[i] = 8'(8'h90 ^ (i * 5));
    run_frame(8'h33, 4, 8'h00, ok);
    chk("final outputs empty", exp_out_q.size(), 0);
    chk("final verdicts empty", exp_ok_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mte_frame_decrypt_checker.md
Name: mte_frame_decrypt_checker

Overview:
Receive-side block for the MTE encryption path. It accepts a stream of encrypted bytes framed by a last-beat MAC tag, decrypts each byte, and forwards the plaintext. It also accumulates a running MAC over the plaintext and compares it with the received tag. At the end of each frame it reports a pass/fail verdict, and it sits between the link receiver and the consumer of plaintext.

Parameters:
N, 8, data/key/tag width in bits
MAX_LEN, 16, maximum data bytes per frame, excluding the tag
IDXW, $clog2(MAX_LEN+1), width of the byte-index counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
key_load  in  1  load key_in into the key register
key_in  in  N  key value
key_valid  out  1  stored key is usable (nonzero)
in_valid  in  1  input beat valid
in_ready  out  1  block can accept an input beat
in_data  in  N  encrypted byte, or the MAC tag when in_last=1
in_last  in  1  this beat is the tag and ends the frame
out_valid  out  1  plaintext beat valid
out_ready  in  1  consumer accepts the plaintext beat
out_data  out  N  decrypted byte
frame_done  out  1  one-cycle pulse when the verdict is valid
frame_ok  out  1  verdict; meaningful only while frame_done=1

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - state=NOKEY; key=0; key_valid=0
  - in_ready=0; out_valid=0; out_data=0
  - frame_done=0; frame_ok=0; idx=0; mac_acc=0
- Transfers: an input beat transfers when in_valid&&in_ready; an output beat transfers when out_valid&&out_ready.
- Decrypt rule: out_data = in_data XOR rotl(key, idx mod N). idx counts data bytes from 0 within the frame and is reset per frame.
- MAC rule: mac_acc ^= plaintext on every data beat. The expected tag is mac_acc XOR key, and frame_ok = (tag == expected).
- Output stage: single register slice.
  - in_ready = (state IDLE or RUN) && (!out_valid || out_ready).
  - A data beat loads out_data/out_valid on the next edge, so latency is 1 cycle.
  - The tag beat is never forwarded.
- FSM:
  - NOKEY: in_ready=0. key_load with key_in!=0 -> IDLE and key_valid=1. key_load with key_in==0 is stored but the block stays in NOKEY.
  - IDLE: key_load is accepted. key_load with key_in==0 -> NOKEY. A first data beat -> RUN. A tag beat (zero-length frame) -> DONE, with expected tag = key.
  - RUN: key_load is ignored (the key is frozen for the frame). Data beats increment idx. A tag beat -> DONE.
  - DONE: exactly one cycle with in_ready=0. frame_done=1 and frame_ok is driven. idx and mac_acc are cleared. Next state is IDLE.
- Overflow: a data beat arriving when idx==MAX_LEN is consumed but not forwarded and not MACed. It sets the sticky ovf flag, and the frame verdict is then forced to frame_ok=0. ovf clears in DONE.
- Backpressure: while out_ready=0 with out_valid=1, in_ready=0 and the output holds stable.
- Simultaneous events:
  - key_load in the same cycle as the first data beat in IDLE: the beat uses the old key and the new key takes effect next frame.
  - Output handoff and a new input beat in the same cycle are both honoured (full throughput).
- Reset mid-frame: all state is discarded, no frame_done is emitted, and the key is lost (back to NOKEY).
- Width rules: idx saturates at MAX_LEN. The rotation amount is idx[$clog2(N)-1:0].

Optional Feature:
- Macro: MTE_FAIL_COUNT_EN.
- Defined: adds output port fail_count[15:0]. It increments on each frame_done with frame_ok=0, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent.

Decomposition:
- Package mte_pkg holds:
  - the state enum (NOKEY, IDLE, RUN, DONE)
  - the default N
  - a function rotl_key(key, amt)
  - a function exp_tag(mac_acc, key)
- The encrypt side imports the same package.
- One sub-module, mte_out_slice: the valid/ready register stage.

Test Plan:
- No key: reset, drive in_valid=1 with in_ready observed -> in_ready=0 and out_valid stays 0.
- Good frame: key=8'h0F; input 8'h0E, 8'h1C, tag 8'h0C(last) -> out 8'h01, 8'h02; then frame_done=1 with frame_ok=1.
- Bad tag: same frame but tag 8'h0D -> same plaintext out; frame_done=1 with frame_ok=0 (fail_count=1 when MTE_FAIL_COUNT_EN is defined).
- Zero-length frame: key=8'h0A; single tag beat 8'h0A(last) -> no output beats; frame_ok=1.
- Backpressure: hold out_ready=0 for 3 cycles mid-frame -> out_data held stable and in_ready=0; the complete plaintext sequence is delivered unchanged after release.
- Overflow and reset: MAX_LEN+1 data beats then a correct tag -> only MAX_LEN outputs and frame_ok=0. Asserting reset_n=0 mid-frame -> key_valid=0, no frame_done.
